// File: rtl/riscv_pkg.sv
// Shared types and constants for the data-memory access path.
package riscv_pkg;
  localparam int XLEN = 32;

  localparam logic [2:0] SIZE_B = 3'b001;
  localparam logic [2:0] SIZE_H = 3'b010;
  localparam logic [2:0] SIZE_W = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } dmem_state_t;

  typedef struct packed {
    logic [XLEN-1:0] adr;
    logic            we;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata;
  } dmem_req_t;

  // Non-one-hot size encodings are treated as misaligned so they never reach the bus.
  function automatic logic is_misaligned(input logic [1:0] off, input logic [2:0] size);
    logic bad;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = off[0];
      SIZE_W:  bad = |off;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction
endpackage

// File: rtl/dmem_align.sv
// Byte-lane steering: store byte enables / replicated write data, and load right-alignment.
module dmem_align
  import riscv_pkg::*;
(
  input  logic [1:0]      req_off_i,
  input  logic [2:0]      req_size_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic [3:0]      be_o,
  output logic [XLEN-1:0] wdata_o,
  input  logic [1:0]      rsp_off_i,
  input  logic [2:0]      rsp_size_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] rdata_o
);
  logic [XLEN-1:0] rdata_sh;

  always_comb begin
    be_o    = 4'b0000;
    wdata_o = req_wdata_i;
    case (req_size_i)
      SIZE_B: begin
        be_o    = 4'b0001 << req_off_i;
        wdata_o = {4{req_wdata_i[7:0]}};
      end
      SIZE_H: begin
        be_o    = 4'b0011 << req_off_i;
        wdata_o = {2{req_wdata_i[15:0]}};
      end
      SIZE_W: be_o = 4'b1111;
      default: ;
    endcase
  end

  assign rdata_sh = rdata_i >> {rsp_off_i, 3'b000};

  always_comb begin
    rdata_o = rdata_sh;
    case (rsp_size_i)
      SIZE_B:  rdata_o = {{(XLEN-8){1'b0}}, rdata_sh[7:0]};
      SIZE_H:  rdata_o = {{(XLEN-16){1'b0}}, rdata_sh[15:0]};
      default: ;
    endcase
  end
endmodule

// File: rtl/dmem_ctrl.sv
// Single-outstanding data-memory controller between the LSU and a req/gnt/rvalid bus.
module dmem_ctrl
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_v_i,
  input  logic [XLEN-1:0] adr_i,
  input  logic            is_store_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [2:0]      access_size_i,
  output logic            stall_o,
  output logic [XLEN-1:0] load_data_o,
  output logic            done_o,
  output logic            misaligned_o,
  output logic            err_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_adr_o,
  output logic [3:0]      mem_be_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  input  logic            mem_err_i
);
  dmem_state_t     state_q, state_d;
  dmem_req_t       req_q, req_d;
  logic [1:0]      off_q, off_d;
  logic [2:0]      size_q, size_d;
  logic [XLEN-1:0] load_data_q, load_data_d;
  logic            err_q, err_d;
  logic [3:0]      be_new;
  logic [XLEN-1:0] wdata_new, rdata_al;
  logic            in_idle;

  dmem_align u_align (
    .req_off_i   (adr_i[1:0]),
    .req_size_i  (access_size_i),
    .req_wdata_i (store_data_i),
    .be_o        (be_new),
    .wdata_o     (wdata_new),
    .rsp_off_i   (off_q),
    .rsp_size_i  (size_q),
    .rdata_i     (mem_rdata_i),
    .rdata_o     (rdata_al)
  );

  assign in_idle      = (state_q == IDLE);
  assign misaligned_o = in_idle & req_v_i & is_misaligned(adr_i[1:0], access_size_i);
  assign stall_o      = (~in_idle & (state_q != DONE)) | (in_idle & req_v_i & ~misaligned_o);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      req_q       <= '0;
      off_q       <= '0;
      size_q      <= '0;
      load_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      off_q       <= off_d;
      size_q      <= size_d;
      load_data_q <= load_data_d;
      err_q       <= err_d;
    end
  end

  // DONE ignores req_v_i: it still belongs to the instruction that is completing.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    off_d       = off_q;
    size_d      = size_q;
    load_data_d = load_data_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (req_v_i && !misaligned_o) begin
          req_d.adr   = {adr_i[XLEN-1:2], 2'b00};
          req_d.we    = is_store_i;
          req_d.be    = be_new;
          req_d.wdata = wdata_new;
          off_d       = adr_i[1:0];
          size_d      = access_size_i;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (mem_gnt_i) begin
          if (req_q.we) begin
            err_d   = mem_err_i;
            state_d = DONE;
          end else begin
            state_d = RSP;
          end
        end
      end
      RSP: begin
        if (mem_rvalid_i) begin
          load_data_d = rdata_al;
          err_d       = mem_err_i;
          state_d     = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_req_o   = (state_q == REQ);
  assign mem_we_o    = req_q.we;
  assign mem_adr_o   = req_q.adr;
  assign mem_be_o    = req_q.be;
  assign mem_wdata_o = req_q.wdata;
  assign done_o      = (state_q == DONE);
  assign load_data_o = load_data_q;
  assign err_o       = err_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Randomized bench for dmem_ctrl against a byte-level reference model.
module tb_dmem_ctrl;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_v_i = 1'b0;
  logic [31:0] adr_i = '0;
  logic        is_store_i = 1'b0;
  logic [31:0] store_data_i = '0;
  logic [2:0]  access_size_i = 3'b100;
  logic        stall_o, done_o, misaligned_o, err_o;
  logic [31:0] load_data_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_adr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_err_i = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  dmem_ctrl dut (
    .clk(clk), .reset_n(reset_n), .req_v_i(req_v_i), .adr_i(adr_i),
    .is_store_i(is_store_i), .store_data_i(store_data_i), .access_size_i(access_size_i),
    .stall_o(stall_o), .load_data_o(load_data_o), .done_o(done_o),
    .misaligned_o(misaligned_o), .err_o(err_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_adr_o(mem_adr_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One access, from request cycle through the cycle after done; bus delays in cycles.
  task automatic run_access(input logic [31:0] adr, input logic st, input logic [2:0] size,
                            input logic [31:0] sd, input int gd, input int rd,
                            input logic [31:0] rdata, input logic e);
    int nb, off;
    logic bad;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, exp_ld, exp_adr;
    off = int'(adr[1:0]);
    case (size)
      3'b001:  nb = 1;
      3'b010:  nb = 2;
      3'b100:  nb = 4;
      default: nb = 0;
    endcase
    bad = (nb == 0) || ((off % nb) != 0);
    exp_be = '0; exp_wd = '0; exp_ld = '0;
    exp_adr = adr & 32'hFFFF_FFFC;
    if (!bad) begin
      for (int k = 0; k < 4; k++) begin
        exp_be[k] = (k >= off) && (k < off + nb);
        exp_wd[8*k +: 8] = sd[8*(k % nb) +: 8];
      end
      for (int i = 0; i < nb; i++) exp_ld[8*i +: 8] = rdata[8*(off+i) +: 8];
    end

    @(negedge clk);
    req_v_i = 1'b1; adr_i = adr; is_store_i = st; access_size_i = size; store_data_i = sd;
    mem_rvalid_i = 1'($urandom_range(0, 1));
    #1;
    check("misaligned", misaligned_o, bad);
    check("stall_issue", stall_o, !bad);
    if (bad) begin
      @(negedge clk);
      check("no_bus_req", mem_req_o, 1'b0);
      check("no_done", done_o, 1'b0);
      check("stall_misal", stall_o, 1'b0);
      req_v_i = 1'b0; mem_rvalid_i = 1'b0;
      return;
    end
    if (!st) exp_q.push_back(exp_ld);

    for (int k = 0; k <= gd; k++) begin
      @(negedge clk);
      check("mem_req", mem_req_o, 1'b1);
      check("stall_req", stall_o, 1'b1);
      check("done_early", done_o, 1'b0);
      check("mem_adr", mem_adr_o, exp_adr);
      check("mem_be", mem_be_o, exp_be);
      check("mem_we", mem_we_o, st);
      if (st) check("mem_wdata", mem_wdata_o, exp_wd);
      mem_gnt_i    = (k == gd);
      mem_err_i    = (k == gd && st) ? e : 1'($urandom_range(0, 1));
      mem_rvalid_i = 1'($urandom_range(0, 1));
      mem_rdata_i  = $urandom;
    end
    if (!st) begin
      for (int k = 0; k <= rd; k++) begin
        @(negedge clk);
        mem_gnt_i = 1'b0;
        check("req_in_rsp", mem_req_o, 1'b0);
        check("stall_rsp", stall_o, 1'b1);
        mem_rvalid_i = (k == rd);
        mem_rdata_i  = (k == rd) ? rdata : $urandom;
        mem_err_i    = (k == rd) ? e : 1'($urandom_range(0, 1));
      end
    end

    @(negedge clk);
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = $urandom;
    check("done", done_o, 1'b1);
    check("stall_done", stall_o, 1'b0);
    check("err", err_o, e);
    check("req_in_done", mem_req_o, 1'b0);
    if (!st) begin
      exp_ld = exp_q.pop_front();
      check("load_data", load_data_o, exp_ld);
    end
    req_v_i = 1'b0;
    #1;
    @(negedge clk);
    check("done_pulse", done_o, 1'b0);
    check("stall_idle", stall_o, 1'b0);
    check("err_hold", err_o, e);
    if (!st) check("load_hold", load_data_o, exp_ld);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, stall_o, 1'b0);
    check({tag, "_ld"}, load_data_o, 32'h0);
    check({tag, "_done"}, done_o, 1'b0);
    check({tag, "_err"}, err_o, 1'b0);
    check({tag, "_req"}, mem_req_o, 1'b0);
    check({tag, "_we"}, mem_we_o, 1'b0);
    check({tag, "_adr"}, mem_adr_o, 32'h0);
    check({tag, "_be"}, mem_be_o, 4'h0);
    check({tag, "_wd"}, mem_wdata_o, 32'h0);
  endtask

  initial begin
    logic [2:0] sizes [0:4];
    sizes[0] = 3'b001; sizes[1] = 3'b010; sizes[2] = 3'b100; sizes[3] = 3'b011; sizes[4] = 3'b000;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    run_access(32'h100, 1'b0, 3'b100, 32'h0, 2, 1, 32'hDEADBEEF, 1'b0);
    run_access(32'h203, 1'b1, 3'b001, 32'h000000A5, 0, 0, 32'h0, 1'b0);
    run_access(32'h102, 1'b0, 3'b010, 32'h0, 1, 0, 32'h1234ABCD, 1'b0);
    run_access(32'h101, 1'b0, 3'b100, 32'h0, 0, 0, 32'h0, 1'b0);
    run_access(32'h003, 1'b0, 3'b010, 32'h0, 0, 0, 32'h0, 1'b0);
    run_access(32'h044, 1'b0, 3'b100, 32'h0, 0, 2, 32'h55AA55AA, 1'b1);
    run_access(32'h048, 1'b1, 3'b010, 32'h0000BEEF, 1, 0, 32'h0, 1'b0);

    // Reset while waiting for the read response.
    @(negedge clk);
    req_v_i = 1'b1; adr_i = 32'h300; is_store_i = 1'b0; access_size_i = 3'b100;
    @(negedge clk);
    mem_gnt_i = 1'b1;
    @(negedge clk);
    mem_gnt_i = 1'b0;
    check("rsp_before_reset", stall_o, 1'b1);
    reset_n = 1'b0; req_v_i = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    check_all_zero("midreset_hold");
    reset_n = 1'b1;
    run_access(32'h104, 1'b0, 3'b100, 32'h0, 0, 0, 32'hCAFEF00D, 1'b0);

    for (int n = 0; n < 60; n++) begin
      logic [2:0] sz;
      sz = (n % 10 == 9) ? sizes[$urandom_range(3, 4)] : sizes[$urandom_range(0, 2)];
      run_access($urandom & 32'h0000_0FFF, 1'($urandom_range(0, 1)), sz, $urandom,
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                 ($urandom_range(0, 7) == 0));
    end

    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
